msfsm_tb_hub: RTL and testbench

//  Parametrised transition-barrier hub for multi-FSM (MSFSM) Mealy decompositions of an STG.

---
 rtl/msfsm_tb_pkg.sv | 20 ++
 rtl/msfsm_tb_evt_cnt.sv | 19 +
 rtl/msfsm_tb_hub.sv | 148 ++++++++++++++
 tb/tb_msfsm_tb_hub.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msfsm_tb_pkg.sv
// rtl/msfsm_tb_pkg.sv - shared helpers and defaults for the MSFSM transition-barrier hub
package msfsm_tb_pkg;

  localparam int DEF_NUM_FSM = 2;
  localparam int DEF_NUM_EVT = 8;
  localparam logic [DEF_NUM_FSM*DEF_NUM_EVT-1:0] DEF_PART_MASK = '1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Flat bit position of (fsm, event) in rdy and PART_MASK.
  function automatic int idx(input int f, input int e, input int num_evt);
    return f * num_evt + e;
  endfunction

endpackage

// File: rtl/msfsm_tb_evt_cnt.sv
// rtl/msfsm_tb_evt_cnt.sv - wrapping per-event fire counter with increment enable
module msfsm_tb_evt_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/msfsm_tb_hub.sv
// rtl/msfsm_tb_hub.sv - central registered barrier for shared transitions of cooperating FSMs
module msfsm_tb_hub
  import msfsm_tb_pkg::*;
#(
  parameter int                         NUM_FSM   = DEF_NUM_FSM,
  parameter int                         NUM_EVT   = DEF_NUM_EVT,
  parameter logic [NUM_FSM*NUM_EVT-1:0] PART_MASK = DEF_PART_MASK,
  parameter int                         DL_LIMIT  = 1024,
  parameter int                         CNT_W     = 16,
  localparam int                        SEL_W     = (NUM_EVT > 1) ? clog2(NUM_EVT) : 1,
  localparam int                        STK_W     = clog2(DL_LIMIT + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic [NUM_FSM*NUM_EVT-1:0] rdy,
  output logic [NUM_EVT-1:0]         fire,
  output logic                       deadlock,
  input  logic                       clr_dl,
  input  logic [SEL_W-1:0]           stat_sel,
  output logic [CNT_W-1:0]           stat_cnt
);

  logic [NUM_EVT-1:0] fire_q;
  logic [NUM_EVT-1:0] enabled;
  logic [NUM_EVT-1:0] partial_v;
  logic [NUM_EVT-1:0] grant;
  logic [NUM_FSM-1:0] locked;
  logic [NUM_FSM-1:0] claimed;
  logic [SEL_W-1:0]   rr;
  logic [SEL_W-1:0]   rr_nxt;
  logic [STK_W-1:0]   stuck;
  logic               partial;
  logic [CNT_W-1:0]   cnt_arr [NUM_EVT];

  function automatic logic [NUM_FSM-1:0] evt_mask(input int e);
    logic [NUM_FSM-1:0] m;
    m = '0;
    for (int f = 0; f < NUM_FSM; f++) m[f] = PART_MASK[idx(f, e, NUM_EVT)];
    return m;
  endfunction

  // An FSM taking a transition this cycle still shows its old rdy; mask it.
  always_comb begin
    locked = '0;
    for (int f = 0; f < NUM_FSM; f++) begin
      for (int e = 0; e < NUM_EVT; e++) begin
        if (PART_MASK[idx(f, e, NUM_EVT)] && fire_q[e]) locked[f] = 1'b1;
      end
    end
  end

  always_comb begin
    logic has;
    logic all_ok;
    logic any_r;
    logic all_r;
    enabled   = '0;
    partial_v = '0;
    has       = 1'b0;
    all_ok    = 1'b0;
    any_r     = 1'b0;
    all_r     = 1'b0;
    for (int e = 0; e < NUM_EVT; e++) begin
      has    = 1'b0;
      all_ok = 1'b1;
      any_r  = 1'b0;
      all_r  = 1'b1;
      for (int f = 0; f < NUM_FSM; f++) begin
        if (PART_MASK[idx(f, e, NUM_EVT)]) begin
          has = 1'b1;
          if (rdy[idx(f, e, NUM_EVT)]) any_r = 1'b1;
          else all_r = 1'b0;
          if (!rdy[idx(f, e, NUM_EVT)] || locked[f]) all_ok = 1'b0;
        end
      end
      enabled[e]   = has & all_ok;
      partial_v[e] = has & any_r & ~all_r;
    end
  end

  assign partial = |partial_v;

  // Round-robin scan from rr; each FSM can be claimed by one event per cycle.
  always_comb begin
    logic [SEL_W:0]   evw;
    logic [SEL_W-1:0] ev;
    logic             found;
    grant   = '0;
    claimed = '0;
    rr_nxt  = rr;
    found   = 1'b0;
    evw     = '0;
    ev      = '0;
    if (en) begin
      for (int k = 0; k < NUM_EVT; k++) begin
        evw = {1'b0, rr} + (SEL_W+1)'(k);
        if (evw >= (SEL_W+1)'(NUM_EVT)) evw = evw - (SEL_W+1)'(NUM_EVT);
        ev = evw[SEL_W-1:0];
        if (enabled[ev] && ((claimed & evt_mask(int'(ev))) == '0)) begin
          grant[ev] = 1'b1;
          claimed   = claimed | evt_mask(int'(ev));
          if (!found) begin
            found  = 1'b1;
            rr_nxt = (int'(ev) == NUM_EVT - 1) ? '0 : ev + SEL_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fire_q   <= '0;
      rr       <= '0;
      stuck    <= '0;
      deadlock <= 1'b0;
    end else begin
      fire_q <= grant;
      if (|grant) rr <= rr_nxt;
      if (clr_dl) begin
        stuck    <= '0;
        deadlock <= 1'b0;
      end else if ((|grant) || !partial) begin
        stuck <= '0;
      end else if (en) begin
        if (stuck < STK_W'(DL_LIMIT)) stuck <= stuck + STK_W'(1);
        if (stuck >= STK_W'(DL_LIMIT - 1)) deadlock <= 1'b1;
      end
    end
  end

  assign fire = fire_q;

  for (genvar e = 0; e < NUM_EVT; e++) begin : g_cnt
    msfsm_tb_evt_cnt #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (fire_q[e] & en),
      .cnt  (cnt_arr[e])
    );
  end

  assign stat_cnt = (int'(stat_sel) < NUM_EVT) ? cnt_arr[stat_sel] : '0;

endmodule

// File: tb/tb_msfsm_tb_hub.sv
// tb/tb_msfsm_tb_hub.sv - randomized and directed bench for msfsm_tb_hub with a behavioural model
module tb_msfsm_tb_hub;

  localparam int NF = 2;
  localparam int NE = 8;
  localparam int DL = 4;
  localparam int CW = 16;
  // e0,e2,e3,e5,e6 shared; e1 FSM0 only; e4 FSM1 only; e7 has no participants.
  localparam logic [NF*NE-1:0] PM = 16'h7D6F;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           en = 1'b0;
  logic           clr_dl = 1'b0;
  logic [NF*NE-1:0] rdy = '0;
  logic [NE-1:0]  fire;
  logic           deadlock;
  logic [2:0]     stat_sel = '0;
  logic [CW-1:0]  stat_cnt;

  int vectors = 0;
  int miscompares = 0;

  logic [NE-1:0] fire_m;
  int            rr_m;
  int            stuck_m;
  bit            dl_m;
  int            cnt_m [NE];
  logic [NF*NE-1:0] pm_v;

  always #5 clk = ~clk;

  msfsm_tb_hub #(
    .NUM_FSM  (NF),
    .NUM_EVT  (NE),
    .PART_MASK(PM),
    .DL_LIMIT (DL),
    .CNT_W    (CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .rdy     (rdy),
    .fire    (fire),
    .deadlock(deadlock),
    .clr_dl  (clr_dl),
    .stat_sel(stat_sel),
    .stat_cnt(stat_cnt)
  );

  function automatic bit part(input int f, input int e);
    return pm_v[f*NE+e];
  endfunction

  task automatic model_reset();
    fire_m  = '0;
    rr_m    = 0;
    stuck_m = 0;
    dl_m    = 0;
    for (int e = 0; e < NE; e++) cnt_m[e] = 0;
  endtask

  // An FSM busy with a transition is unavailable; an event fires when all of
  // its FSMs are ready, free and not already taken earlier in the walk.
  task automatic model_next(output logic [NE-1:0] g, output int rr_n,
                            output int stk_n, output bit dl_n);
    bit busy [NF];
    bit taken [NF];
    bit first_done;
    bit some_partial;
    g = '0;
    rr_n = rr_m;
    first_done = 0;
    some_partial = 0;
    for (int f = 0; f < NF; f++) begin
      busy[f] = 0;
      taken[f] = 0;
      for (int e = 0; e < NE; e++) if (part(f, e) && fire_m[e]) busy[f] = 1;
    end
    for (int e = 0; e < NE; e++) begin
      int n, r;
      n = 0;
      r = 0;
      for (int f = 0; f < NF; f++) if (part(f, e)) begin
        n++;
        if (rdy[f*NE+e]) r++;
      end
      if (r > 0 && r < n) some_partial = 1;
    end
    if (en) begin
      for (int k = 0; k < NE; k++) begin
        int e, n;
        bit ok;
        e = (rr_m + k) % NE;
        n = 0;
        ok = 1;
        for (int f = 0; f < NF; f++) if (part(f, e)) begin
          n++;
          if (!rdy[f*NE+e] || busy[f] || taken[f]) ok = 0;
        end
        if (n > 0 && ok) begin
          g[e] = 1'b1;
          for (int f = 0; f < NF; f++) if (part(f, e)) taken[f] = 1;
          if (!first_done) begin
            first_done = 1;
            rr_n = (e + 1) % NE;
          end
        end
      end
    end
    stk_n = stuck_m;
    dl_n = dl_m;
    if (clr_dl) begin
      stk_n = 0;
      dl_n = 0;
    end else if (g != 0 || !some_partial) begin
      stk_n = 0;
    end else if (en) begin
      if (stk_n < DL) stk_n++;
      if (stk_n >= DL) dl_n = 1;
    end
  endtask

  task automatic tick();
    logic [NE-1:0] g;
    int rn, sn;
    bit dn;
    model_next(g, rn, sn, dn);
    @(posedge clk);
    for (int e = 0; e < NE; e++) if (en && fire_m[e]) cnt_m[e] = (cnt_m[e] + 1) % 65536;
    fire_m = g;
    rr_m = rn;
    stuck_m = sn;
    dl_m = dn;
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (fire !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_fire got=%h exp=00", fire);
    end
    vectors++;
    if (deadlock !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_deadlock got=%b exp=0", deadlock);
    end
    for (int s = 0; s < NE; s++) begin
      stat_sel = 3'(s);
      #1;
      vectors++;
      if (stat_cnt !== 16'h0000) begin
        miscompares++;
        $display("FAIL reset_cnt sel=%0d got=%h exp=0000", s, stat_cnt);
      end
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_barrier();
    en = 1'b1;
    rdy = '0;
    rdy[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (fire !== 8'h00 || fire !== fire_m) begin
        miscompares++;
        $display("FAIL barrier_partial cyc=%0d got=%h exp=00", i, fire);
      end
    end
    rdy[NE+0] = 1'b1;
    tick();
    vectors++;
    if (fire !== 8'h01 || fire !== fire_m) begin
      miscompares++;
      $display("FAIL barrier_fire got=%h exp=01", fire);
    end
    rdy = '0;
    tick();
    vectors++;
    if (fire !== 8'h00 || deadlock !== dl_m) begin
      miscompares++;
      $display("FAIL barrier_after got=%h/%b exp=00/%b", fire, deadlock, dl_m);
    end
  endtask

  task automatic test_choice();
    logic [NE-1:0] prev;
    int grants;
    prev = '0;
    grants = 0;
    rdy = '0;
    rdy[2] = 1'b1;
    rdy[3] = 1'b1;
    rdy[NE+2] = 1'b1;
    rdy[NE+3] = 1'b1;
    for (int i = 0; i < 12 && grants < 4; i++) begin
      tick();
      vectors++;
      if (fire !== fire_m) begin
        miscompares++;
        $display("FAIL choice_model cyc=%0d got=%h exp=%h", i, fire, fire_m);
      end
      if (fire !== 8'h00) begin
        grants++;
        vectors++;
        if ((fire !== 8'h04 && fire !== 8'h08) || fire === prev) begin
          miscompares++;
          $display("FAIL choice_alt cyc=%0d got=%h prev=%h exp=other_of_04_08", i, fire, prev);
        end
        prev = fire;
      end
    end
    vectors++;
    if (grants != 4) begin
      miscompares++;
      $display("FAIL choice_count got=%0d exp=4", grants);
    end
    rdy = '0;
    tick();
  endtask

  task automatic test_independent();
    rdy = '0;
    rdy[1] = 1'b1;
    rdy[NE+4] = 1'b1;
    tick();
    vectors++;
    if (fire !== 8'h12 || fire !== fire_m) begin
      miscompares++;
      $display("FAIL indep_fire got=%h exp=12", fire);
    end
    rdy = '0;
    tick();
    vectors++;
    if (fire !== 8'h00) begin
      miscompares++;
      $display("FAIL indep_after got=%h exp=00", fire);
    end
  endtask

  task automatic test_stuck();
    rdy = '0;
    clr_dl = 1'b1;
    tick();
    clr_dl = 1'b0;
    rdy[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      vectors++;
      if (deadlock !== (i == 4) || deadlock !== dl_m) begin
        miscompares++;
        $display("FAIL stuck_dl cyc=%0d got=%b exp=%b", i, deadlock, (i == 4));
      end
    end
    tick();
    vectors++;
    if (deadlock !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_sticky got=%b exp=1", deadlock);
    end
    clr_dl = 1'b1;
    tick();
    vectors++;
    if (deadlock !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_clr got=%b exp=0", deadlock);
    end
    clr_dl = 1'b0;
    rdy = '0;
    tick();
  endtask

  task automatic test_lock();
    int pulses;
    bit prev;
    pulses = 0;
    prev = 0;
    rdy = '0;
    rdy[0] = 1'b1;
    rdy[NE+0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if (fire !== fire_m || (fire[0] && prev)) begin
        miscompares++;
        $display("FAIL lock_fire cyc=%0d got=%h exp=%h", i, fire, fire_m);
      end
      if (fire[0]) pulses++;
      prev = fire[0];
    end
    vectors++;
    if (pulses != 3) begin
      miscompares++;
      $display("FAIL lock_pulses got=%0d exp=3", pulses);
    end
    rdy = '0;
    tick();
  endtask

  task automatic test_en();
    stat_sel = 3'd0;
    rdy = '0;
    rdy[0] = 1'b1;
    rdy[NE+0] = 1'b1;
    tick();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (fire !== 8'h00 || stat_cnt !== 16'(cnt_m[0])) begin
        miscompares++;
        $display("FAIL en_freeze cyc=%0d got=%h/%0d exp=00/%0d", i, fire, stat_cnt, cnt_m[0]);
      end
    end
    en = 1'b1;
    rdy = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    stat_sel = 3'd0;
    rdy = '0;
    rdy[0] = 1'b1;
    rdy[NE+0] = 1'b1;
    tick();
    vectors++;
    if (fire !== 8'h01 || stat_cnt === 16'h0000) begin
      miscompares++;
      $display("FAIL rstmid_pre got=%h/%0d exp=01/nonzero", fire, stat_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (fire !== 8'h00 || stat_cnt !== 16'h0000 || deadlock !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async got=%h/%0d/%b exp=00/0/0", fire, stat_cnt, deadlock);
    end
    model_reset();
    rdy = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NF*NE; b++) rdy[b] = ($urandom_range(0, 9) < 6);
      en = ($urandom_range(0, 9) != 0);
      clr_dl = ($urandom_range(0, 19) == 0);
      stat_sel = 3'($urandom_range(0, NE-1));
      tick();
      vectors++;
      if (fire !== fire_m || deadlock !== dl_m || stat_cnt !== 16'(cnt_m[stat_sel])) begin
        miscompares++;
        $display("FAIL random cyc=%0d fire=%h/%h dl=%b/%b cnt[%0d]=%0d/%0d", i,
                 fire, fire_m, deadlock, dl_m, stat_sel, stat_cnt, cnt_m[stat_sel]);
      end
    end
    en = 1'b1;
    clr_dl = 1'b0;
    rdy = '0;
  endtask

  initial begin
    pm_v = PM;
    model_reset();
    test_reset();
    test_barrier();
    test_choice();
    test_independent();
    test_stuck();
    test_lock();
    test_en();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
